// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//   Shares the register bank's single write port between the ALU result path
//   and the memory load path, and keeps a pending-write scoreboard so the
//   issue logic can stall on read-after-write hazards.
//
//   Loads normally win a conflict. After the ALU has lost STARVE_MAX
//   consecutive cycles, it is forced to win once.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   alu_valid/rd/data     ALU write request (valid/ready handshake)
//   alu_ready             ALU request accepted when high with alu_valid
//   mem_valid/rd/data     load write request (valid/ready handshake)
//   mem_ready             load request accepted when high with mem_valid
//   issue_en, issue_rd    issued instruction will write issue_rd
//   rs1_sel (6b)          A-port selector; values 32..63 select PC
//   rs2_sel (5b)          B-port selector
//   rs1_busy, rs2_busy    selected register has an outstanding write
//   rd, busC              registered write address/data to the bank (rd 0 = none)
//   wb_fire               registered pulse: a write was issued to the bank
//   wb_err                sticky: accepted write to a non-pending register
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [4:0]        alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [4:0]        mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              issue_en,
  input  logic [4:0]        issue_rd,
  input  logic [5:0]        rs1_sel,
  input  logic [4:0]        rs2_sel,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic [4:0]        rd,
  output logic [DATA_W-1:0] busC,
  output logic              wb_fire,
  output logic              wb_err
);

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [2:0]        starve_q, starve_d;
  logic [31:0]       pending_q, pending_d;
  logic [4:0]        rd_q, rd_d;
  logic [DATA_W-1:0] busc_q, busc_d;
  logic              fire_q, fire_d;
  logic              err_q, err_d;

  logic              starve_hit;
  logic              alu_acc;
  logic              mem_acc;
  logic              acc;
  logic [4:0]        win_rd;
  logic [DATA_W-1:0] win_data;

  // Arbitration: loads win unless the ALU has been starved long enough.
  // Both readies are gated by reset so nothing is accepted while it is low.
  assign starve_hit = (starve_q == STARVE_LIM);
  assign mem_ready  = reset && (!alu_valid || !starve_hit);
  assign alu_ready  = reset && (!mem_valid ||  starve_hit);

  assign alu_acc = alu_valid && alu_ready;
  assign mem_acc = mem_valid && mem_ready;
  assign acc     = alu_acc || mem_acc;

  // At most one of the two accepts is high, so a simple mux picks the winner.
  assign win_rd   = alu_acc ? alu_rd   : mem_rd;
  assign win_data = alu_acc ? alu_data : mem_data;

  // Busy is read straight from the registered scoreboard; a clear at posedge N
  // is safe to expose from N because the bank captures on the following negedge.
  assign rs1_busy = !rs1_sel[5] && pending_q[rs1_sel[4:0]];
  assign rs2_busy = pending_q[rs2_sel];

  assign rd      = rd_q;
  assign busC    = busc_q;
  assign wb_fire = fire_q;
  assign wb_err  = err_q;

  always_comb begin
    starve_d  = starve_q;
    pending_d = pending_q;
    rd_d      = 5'd0;
    busc_d    = busc_q;
    fire_d    = 1'b0;
    err_d     = err_q;

    if (!alu_valid || alu_acc) begin
      starve_d = 3'd0;
    end else if (!starve_hit) begin
      starve_d = starve_q + 3'd1;
    end

    if (acc) begin
      rd_d   = win_rd;
      busc_d = win_data;
      fire_d = (win_rd != 5'd0);
      if ((win_rd != 5'd0) && !pending_q[win_rd]) begin
        err_d = 1'b1;
      end
      pending_d[win_rd] = 1'b0;
    end

    // Set is applied after clear so a same-cycle issue to the same register wins.
    if (issue_en) begin
      pending_d[issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Register stage: write-back port, scoreboard and starvation counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q  <= 3'd0;
      pending_q <= 32'd0;
      rd_q      <= 5'd0;
      busc_q    <= '0;
      fire_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      pending_q <= pending_d;
      rd_q      <= rd_d;
      busc_q    <= busc_d;
      fire_q    <= fire_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              alu_valid;
  logic [4:0]        alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [4:0]        mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              issue_en;
  logic [4:0]        issue_rd;
  logic [5:0]        rs1_sel;
  logic [4:0]        rs2_sel;
  logic              rs1_busy;
  logic              rs2_busy;
  logic [4:0]        rd;
  logic [DATA_W-1:0] busC;
  logic              wb_fire;
  logic              wb_err;

  int tests_run;
  int fails;

  rf_wb_arbiter #(.DATA_W(DATA_W), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rd(rd), .busC(busC), .wb_fire(wb_fire), .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] r);
    issue_en = 1'b1;
    issue_rd = r;
    tick();
    issue_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; alu_valid = 1'b1; mem_valid = 1'b1;
    alu_rd = 5'd1; mem_rd = 5'd2; alu_data = '0; mem_data = '0;
    issue_en = 1'b0; issue_rd = 5'd0; rs1_sel = 6'd0; rs2_sel = 5'd0;
    #2 reset = 1'b0;
    #1;
    tests_run++; if (alu_ready !== 1'b0) begin fails++; $display("FAIL rst_alu_ready: got %b want 0", alu_ready); end
    tests_run++; if (mem_ready !== 1'b0) begin fails++; $display("FAIL rst_mem_ready: got %b want 0", mem_ready); end
    tick(); tick();
    tests_run++; if (rd !== 5'd0) begin fails++; $display("FAIL rst_rd: got %0d want 0", rd); end
    tests_run++; if (busC !== 32'd0) begin fails++; $display("FAIL rst_busC: got %h want 0", busC); end
    tests_run++; if (wb_fire !== 1'b0) begin fails++; $display("FAIL rst_wb_fire: got %b want 0", wb_fire); end
    tests_run++; if (wb_err !== 1'b0) begin fails++; $display("FAIL rst_wb_err: got %b want 0", wb_err); end
    alu_valid = 1'b0; mem_valid = 1'b0;
    reset = 1'b1;
    #1;
    tests_run++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL idle_alu_ready: got %b want 1", alu_ready); end
    tests_run++; if (mem_ready !== 1'b1) begin fails++; $display("FAIL idle_mem_ready: got %b want 1", mem_ready); end
    tick();
  endtask

  task automatic test_single_alu();
    rs1_sel = 6'd5; rs2_sel = 5'd5;
    issue_en = 1'b1; issue_rd = 5'd5;
    #1;
    tests_run++; if (rs1_busy !== 1'b0) begin fails++; $display("FAIL alu_busy_pre: got %b want 0", rs1_busy); end
    tick();
    issue_en = 1'b0;
    tests_run++; if (rs1_busy !== 1'b1) begin fails++; $display("FAIL alu_rs1_busy_set: got %b want 1", rs1_busy); end
    tests_run++; if (rs2_busy !== 1'b1) begin fails++; $display("FAIL alu_rs2_busy_set: got %b want 1", rs2_busy); end
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    tests_run++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL alu_ready: got %b want 1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    tests_run++; if (rd !== 5'd5) begin fails++; $display("FAIL alu_rd_out: got %0d want 5", rd); end
    tests_run++; if (busC !== 32'hDEADBEEF) begin fails++; $display("FAIL alu_busC: got %h want deadbeef", busC); end
    tests_run++; if (wb_fire !== 1'b1) begin fails++; $display("FAIL alu_wb_fire: got %b want 1", wb_fire); end
    tests_run++; if (rs1_busy !== 1'b0) begin fails++; $display("FAIL alu_rs1_busy_clr: got %b want 0", rs1_busy); end
    tests_run++; if (wb_err !== 1'b0) begin fails++; $display("FAIL alu_wb_err: got %b want 0", wb_err); end
    tick();
    tests_run++; if (rd !== 5'd0) begin fails++; $display("FAIL alu_rd_idle: got %0d want 0", rd); end
    tests_run++; if (wb_fire !== 1'b0) begin fails++; $display("FAIL alu_fire_idle: got %b want 0", wb_fire); end
    tests_run++; if (busC !== 32'hDEADBEEF) begin fails++; $display("FAIL alu_busC_hold: got %h want deadbeef", busC); end
  endtask

  task automatic test_starvation();
    logic [4:0] mem_list [6];
    logic [4:0] alu_list [2];
    logic [4:0] exp_rd;
    logic       exp_alu;
    int mi;
    int ai;
    mem_list = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
    alu_list = '{5'd20, 5'd21};
    for (int k = 0; k < 6; k++) issue(mem_list[k]);
    for (int k = 0; k < 2; k++) issue(alu_list[k]);
    mi = 0; ai = 0;
    mem_valid = 1'b1; mem_rd = mem_list[0]; mem_data = 32'hA0000000 | 32'(mem_list[0]);
    alu_valid = 1'b1; alu_rd = alu_list[0]; alu_data = 32'hB0000000 | 32'(alu_list[0]);
    for (int i = 0; i < 8; i++) begin
      exp_alu = ((i % 4) == 3);
      exp_rd  = exp_alu ? alu_list[ai] : mem_list[mi];
      #1;
      tests_run++; if (alu_ready !== exp_alu) begin fails++; $display("FAIL starve_alu_ready[%0d]: got %b want %b", i, alu_ready, exp_alu); end
      tests_run++; if (mem_ready !== !exp_alu) begin fails++; $display("FAIL starve_mem_ready[%0d]: got %b want %b", i, mem_ready, !exp_alu); end
      tick();
      tests_run++; if (rd !== exp_rd) begin fails++; $display("FAIL starve_rd[%0d]: got %0d want %0d", i, rd, exp_rd); end
      tests_run++; if (busC !== ((exp_alu ? 32'hB0000000 : 32'hA0000000) | 32'(exp_rd))) begin fails++; $display("FAIL starve_busC[%0d]: got %h want %h", i, busC, (exp_alu ? 32'hB0000000 : 32'hA0000000) | 32'(exp_rd)); end
      if (exp_alu) begin
        ai++;
        if (ai < 2) begin alu_rd = alu_list[ai]; alu_data = 32'hB0000000 | 32'(alu_list[ai]); end
      end else begin
        mi++;
        if (mi < 6) begin mem_rd = mem_list[mi]; mem_data = 32'hA0000000 | 32'(mem_list[mi]); end
      end
    end
    mem_valid = 1'b0; alu_valid = 1'b0;
    rs2_sel = 5'd21;
    #1;
    tests_run++; if (rs2_busy !== 1'b0) begin fails++; $display("FAIL starve_pending_clr: got %b want 0", rs2_busy); end
    tests_run++; if (wb_err !== 1'b0) begin fails++; $display("FAIL starve_wb_err: got %b want 0", wb_err); end
    tick();
  endtask

  task automatic test_set_clear();
    rs2_sel = 5'd7;
    issue(5'd7);
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h00000077;
    issue_en = 1'b1; issue_rd = 5'd7;
    tick();
    issue_en = 1'b0; mem_valid = 1'b0;
    tests_run++; if (rd !== 5'd7) begin fails++; $display("FAIL sc_rd: got %0d want 7", rd); end
    tests_run++; if (rs2_busy !== 1'b1) begin fails++; $display("FAIL sc_set_wins: got %b want 1", rs2_busy); end
    tests_run++; if (wb_err !== 1'b0) begin fails++; $display("FAIL sc_wb_err: got %b want 0", wb_err); end
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h00000078;
    tick();
    mem_valid = 1'b0;
    tests_run++; if (rs2_busy !== 1'b0) begin fails++; $display("FAIL sc_final_clear: got %b want 0", rs2_busy); end
    tests_run++; if (wb_err !== 1'b0) begin fails++; $display("FAIL sc_wb_err2: got %b want 0", wb_err); end
  endtask

  task automatic test_x0_pc();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h00001234;
    issue_en = 1'b1; issue_rd = 5'd0;
    rs1_sel = 6'd0; rs2_sel = 5'd0;
    #1;
    tests_run++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL x0_alu_ready: got %b want 1", alu_ready); end
    tick();
    alu_valid = 1'b0; issue_en = 1'b0;
    tests_run++; if (rd !== 5'd0) begin fails++; $display("FAIL x0_rd: got %0d want 0", rd); end
    tests_run++; if (wb_fire !== 1'b0) begin fails++; $display("FAIL x0_wb_fire: got %b want 0", wb_fire); end
    tests_run++; if (wb_err !== 1'b0) begin fails++; $display("FAIL x0_wb_err: got %b want 0", wb_err); end
    tests_run++; if (busC !== 32'h00001234) begin fails++; $display("FAIL x0_busC: got %h want 00001234", busC); end
    tests_run++; if (rs2_busy !== 1'b0) begin fails++; $display("FAIL x0_busy: got %b want 0", rs2_busy); end
    for (int r = 1; r < 32; r++) issue(5'(r));
    rs1_sel = 6'd31; rs2_sel = 5'd0;
    #1;
    tests_run++; if (rs1_busy !== 1'b1) begin fails++; $display("FAIL pc_rs1_31: got %b want 1", rs1_busy); end
    tests_run++; if (rs2_busy !== 1'b0) begin fails++; $display("FAIL pc_rs2_x0: got %b want 0", rs2_busy); end
    rs1_sel = 6'd0; #1;
    tests_run++; if (rs1_busy !== 1'b0) begin fails++; $display("FAIL pc_rs1_x0: got %b want 0", rs1_busy); end
    rs1_sel = 6'd32; #1;
    tests_run++; if (rs1_busy !== 1'b0) begin fails++; $display("FAIL pc_rs1_32: got %b want 0", rs1_busy); end
    rs1_sel = 6'd37; #1;
    tests_run++; if (rs1_busy !== 1'b0) begin fails++; $display("FAIL pc_rs1_37: got %b want 0", rs1_busy); end
    rs1_sel = 6'd63; #1;
    tests_run++; if (rs1_busy !== 1'b0) begin fails++; $display("FAIL pc_rs1_63: got %b want 0", rs1_busy); end
    tick();
  endtask

  task automatic test_async_reset();
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'hA5A50003;
    tick();
    tests_run++; if (rd !== 5'd3) begin fails++; $display("FAIL ar_pre_rd: got %0d want 3", rd); end
    mem_rd = 5'd4; mem_data = 32'hA5A50004;
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'hB5B50006;
    rs1_sel = 6'd31; rs2_sel = 5'd4;
    #1 reset = 1'b0;
    #1;
    tests_run++; if (rd !== 5'd0) begin fails++; $display("FAIL ar_rd: got %0d want 0", rd); end
    tests_run++; if (busC !== 32'd0) begin fails++; $display("FAIL ar_busC: got %h want 0", busC); end
    tests_run++; if (wb_fire !== 1'b0) begin fails++; $display("FAIL ar_wb_fire: got %b want 0", wb_fire); end
    tests_run++; if (alu_ready !== 1'b0) begin fails++; $display("FAIL ar_alu_ready: got %b want 0", alu_ready); end
    tests_run++; if (mem_ready !== 1'b0) begin fails++; $display("FAIL ar_mem_ready: got %b want 0", mem_ready); end
    tests_run++; if (rs1_busy !== 1'b0) begin fails++; $display("FAIL ar_rs1_busy: got %b want 0", rs1_busy); end
    tests_run++; if (rs2_busy !== 1'b0) begin fails++; $display("FAIL ar_rs2_busy: got %b want 0", rs2_busy); end
    tick();
    tests_run++; if (rd !== 5'd0) begin fails++; $display("FAIL ar_no_write: got %0d want 0", rd); end
    tests_run++; if (wb_fire !== 1'b0) begin fails++; $display("FAIL ar_no_fire: got %b want 0", wb_fire); end
    mem_valid = 1'b0; alu_valid = 1'b0;
    reset = 1'b1;
    tick();
    tests_run++; if (wb_err !== 1'b0) begin fails++; $display("FAIL ar_wb_err: got %b want 0", wb_err); end
  endtask

  task automatic test_unexpected();
    rs2_sel = 5'd9;
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h00000099;
    #1;
    tests_run++; if (mem_ready !== 1'b1) begin fails++; $display("FAIL ux_mem_ready: got %b want 1", mem_ready); end
    tick();
    mem_valid = 1'b0;
    tests_run++; if (rd !== 5'd9) begin fails++; $display("FAIL ux_rd: got %0d want 9", rd); end
    tests_run++; if (wb_fire !== 1'b1) begin fails++; $display("FAIL ux_wb_fire: got %b want 1", wb_fire); end
    tests_run++; if (wb_err !== 1'b1) begin fails++; $display("FAIL ux_wb_err: got %b want 1", wb_err); end
    tests_run++; if (rs2_busy !== 1'b0) begin fails++; $display("FAIL ux_busy: got %b want 0", rs2_busy); end
    tick(); tick(); tick();
    tests_run++; if (wb_err !== 1'b1) begin fails++; $display("FAIL ux_wb_err_sticky: got %b want 1", wb_err); end
    #1 reset = 1'b0;
    #1;
    tests_run++; if (wb_err !== 1'b0) begin fails++; $display("FAIL ux_wb_err_reset: got %b want 0", wb_err); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    tests_run = 0;
    fails     = 0;
    test_reset();
    test_single_alu();
    test_starvation();
    test_set_clear();
    test_x0_pc();
    test_async_reset();
    test_unexpected();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and pending-write scoreboard for the 32x32 register bank. It shares the bank's single write port (`rd`/`busC`) between the ALU result path and the memory load path using valid/ready handshakes with anti-starvation. It also tracks registers that have an outstanding write, so the issue logic can stall on read-after-write hazards on the bank's A/B read selectors.

## Interface
- `DATA_W`, 32: write data width.
- `STARVE_MAX`, 3: number of consecutive cycles the ALU may lose arbitration before it is forced to win. Range 1..7.

- `clk` in 1: clock. All state updates on posedge.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `alu_valid` in 1: ALU write request.
- `alu_rd` in 5: ALU destination register.
- `alu_data` in DATA_W: ALU write data.
- `alu_ready` out 1: ALU request accepted this cycle when high with `alu_valid`.
- `mem_valid` in 1: load write request.
- `mem_rd` in 5: load destination register.
- `mem_data` in DATA_W: load write data.
- `mem_ready` out 1: load request accepted this cycle when high with `mem_valid`.
- `issue_en` in 1: an instruction writing `issue_rd` was issued.
- `issue_rd` in 5: destination of the issued instruction.
- `rs1_sel` in 6: A-port selector. Values 32..63 mean PC and are never busy.
- `rs2_sel` in 5: B-port selector.
- `rs1_busy` out 1: `rs1_sel` has a pending write.
- `rs2_busy` out 1: `rs2_sel` has a pending write.
- `rd` out 5: registered write address to the bank. 0 means no write.
- `busC` out DATA_W: registered write data to the bank.
- `wb_fire` out 1: registered pulse, a write was issued to the bank this cycle.
- `wb_err` out 1: sticky flag, a write was accepted to a register that was not pending.

## Operation
- **Arbitration (combinational):**
  - `starve_hit = (starve_cnt == STARVE_MAX)`.
  - `mem_ready = !reset_n_active && (!alu_valid || !starve_hit)`.
  - `alu_ready = !reset_n_active && (!mem_valid || starve_hit)`.
  - Loads have priority unless `starve_hit`. Exactly one request is accepted when both are valid.
- **Handshake:**
  - Transfer occurs when valid and ready are high at posedge.
  - Requesters hold valid and payload stable until accepted.
  - Ready may be high with valid low.
- **starve_cnt (3 bits):**
  - Increments, saturating at STARVE_MAX, on each cycle with `alu_valid && !alu_ready`.
  - Clears on ALU accept or when `alu_valid` is low.
- **Write-back register:**
  - On accept, `rd` <= winner rd, `busC` <= winner data, `wb_fire` <= (winner rd != 0).
  - With no accept, `rd` <= 0, `busC` holds, `wb_fire` <= 0.
  - An accepted write to x0 completes the handshake but produces `rd` = 0.
- **Scoreboard (`pending[31:1]`; bit 0 is constant 0):**
  - `issue_en` with `issue_rd` != 0 sets the bit.
  - An accepted write clears the bit of the winner's rd.
  - If set and clear hit the same register in the same cycle, set wins.
  - Setting an already-set bit leaves it set; there is no counting, so a register has at most one outstanding write.
- **Busy outputs:**
  - `rs1_busy = rs1_sel < 32 && pending[rs1_sel[4:0]]`.
  - `rs2_busy = pending[rs2_sel]`.
  - Selector 0 is never busy.
- **`wb_err`:** set on accept of a write with rd != 0 whose pending bit was 0. Cleared only by reset.

## Timing
- **Reset values:** `rd` = 0, `busC` = 0, `wb_fire` = 0, `wb_err` = 0, pending = 0, `starve_cnt` = 0. `alu_ready` and `mem_ready` are forced 0 while reset is low.
- **Reset mid-operation:** in-flight requests are dropped, not accepted. Requesters re-present them after reset.
- **Write latency:**
  - Accept at posedge N drives `rd`/`busC` from N. The bank captures on the following negedge (N + half cycle).
  - Data is readable from the bank before posedge N+1.
- **Busy latency:**
  - A bit set by `issue_en` at posedge N makes busy high from N.
  - A bit cleared by accept at posedge N makes busy low from N. This is safe because the bank write lands at negedge before the consumer samples at N+1.
- **Paths:** ready and busy are combinational from inputs and state. There is no valid-to-ready loop on the same requester.

## Test plan
- **Single ALU write:**
  - Stimulus: `issue_en` rd=5; next cycle `alu_valid` rd=5 data=0xDEADBEEF.
  - Response: `alu_ready` = 1. Next cycle `rd` = 5, `busC` = 0xDEADBEEF, `wb_fire` = 1. `rs1_busy` for sel=5 high, then low after accept. `wb_err` = 0.
- **Contention and starvation with STARVE_MAX = 3:**
  - Stimulus: `mem_valid` and `alu_valid` held high continuously with distinct pending rds.
  - Response: mem accepted 3 cycles, ALU accepted on the 4th, then the pattern repeats.
- **Same-cycle set and clear:**
  - Stimulus: accept a write to rd=7 in the same cycle as `issue_en` rd=7.
  - Response: `pending[7]` stays 1 and `rs2_busy` (sel=7) stays high.
- **x0 and PC handling:**
  - Stimulus: ALU write rd=0, and `issue_en` rd=0.
  - Response: handshake completes, `rd` = 0, `wb_fire` = 0, no pending change, `wb_err` = 0. `rs1_sel` = 32..63 gives `rs1_busy` = 0 even with all pending bits set.
- **Unexpected write:**
  - Stimulus: `mem_valid` rd=9 with `pending[9]` = 0.
  - Response: write issued (`rd` = 9), `wb_err` = 1 and stays 1.
- **Async reset mid-request:**
  - Stimulus: assert reset low between clock edges while both requests are valid.
  - Response: all outputs and pending go to 0 immediately, both readies are 0, and no write occurs.
